// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: IDLE/RUN/HALT control around an instruction ROM and decoder.
// Optional executed-cycle counter enabled by defining FETCH_SEQ_CYCLE_COUNT_EN.
module fetch_seq (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [8:0]  InstrIn,
   input  logic        BranchEn,
   input  logic [8:0]  BranchTarget,
   input  logic [1:0]  NextState,
   input  logic [8:0]  PrevInstructionOut,
   input  logic        Ack,
   output logic [8:0]  ProgCtr,
   output logic [8:0]  Instruction,
   output logic [1:0]  CurrState,
   output logic [8:0]  PrevInstruction,
   output logic        Running,
   output logic        Done,
   output logic [15:0] CycleCnt
);

   localparam int unsigned AddrW  = 9;
   localparam int unsigned InstrW = 9;
   localparam int unsigned ModeW  = 2;
   localparam int unsigned CntW   = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HALT = 2'b10
   } state_e;

   state_e              state_q, state_d;
   logic [AddrW-1:0]    pc_q, pc_d;
   logic [ModeW-1:0]    curr_q, curr_d;
   logic [InstrW-1:0]   prev_q, prev_d;
   logic                running_q, running_d;
   logic                done_q, done_d;

   // Next-state and datapath update; Ack takes priority over branch and restart in RUN.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      curr_d  = curr_q;
      prev_d  = prev_q;
      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (Start) begin
               state_d = S_RUN;
               pc_d    = '0;
               curr_d  = '0;
               prev_d  = '0;
            end
         end
         S_RUN: begin
            if (Ack) begin
               state_d = S_HALT;
               curr_d  = '0;
            end else begin
               pc_d   = BranchEn ? BranchTarget : pc_q + AddrW'(1);
               curr_d = NextState;
               prev_d = PrevInstructionOut;
            end
         end
         default: begin
            state_d = S_IDLE;
            pc_d    = '0;
            curr_d  = '0;
            prev_d  = '0;
         end
      endcase
      running_d = (state_d == S_RUN);
      done_d    = (state_d == S_HALT);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         curr_q    <= '0;
         prev_q    <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         curr_q    <= curr_d;
         prev_q    <= prev_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign ProgCtr         = pc_q;
   assign CurrState       = curr_q;
   assign PrevInstruction = prev_q;
   assign Running         = running_q;
   assign Done            = done_q;
   // ROM data passes straight through while running; NOP otherwise.
   assign Instruction     = running_q ? InstrIn : InstrW'(0);

`ifdef FETCH_SEQ_CYCLE_COUNT_EN
   logic [CntW-1:0] cnt_q, cnt_d;

   // Cleared on an accepted Start, saturating count of RUN cycles.
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q != S_RUN) && Start) begin
         cnt_d = '0;
      end else if ((state_q == S_RUN) && (cnt_q != {CntW{1'b1}})) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign CycleCnt = cnt_q;
`else
   assign CycleCnt = CntW'(0);
`endif

endmodule
